// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes 33-bit instructions into imem and holds the core in reset while loading
//   Frame: CNT_HI CNT_LO, then N instructions of NB bytes each, MSB first (first byte carries only instr[32]).
//   Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//   Ports: clk, rst (sync, active-high), load_start, rx_data/rx_valid/rx_ready (byte link),
//          imem_we/imem_addr/imem_wdata (imem write port), cpu_rst_o, load_done, load_err.
module imem_loader #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 33,
  parameter int DEPTH   = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst_o,
  output logic               load_done,
  output logic               load_err
);
  localparam int NB = (INSTR_W + 7) / 8;
  localparam int AW = INSTR_W - 8;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, BYTES, WRITE, DONE, ERROR, CSUM} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bidx;
  logic [AW-1:0] r_asm;
  logic        w_acc;
  logic [15:0] w_n;
  assign w_acc = rx_valid && rx_ready;
  assign w_n   = {r_cnt[15:8], rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  // running XOR of every accepted byte; cleared whenever a new load begins
  always_ff @(posedge clk)
    if (rst || load_start && (r_state == IDLE || r_state == DONE || r_state == ERROR)) r_csum <= 8'd0;
    else if (w_acc) r_csum <= r_csum ^ rx_data;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 16'd0;
      r_bidx     <= 3'd0;
      r_asm      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_o  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: if (load_start) begin
          r_state   <= HDR0;
          r_bidx    <= 3'd0;
          rx_ready  <= 1'b1;
          imem_addr <= '0;
          cpu_rst_o <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b0;
        end
        HDR0: if (w_acc) begin
          r_cnt[15:8] <= rx_data;
          r_state     <= HDR1;
        end
        HDR1: if (w_acc) begin
          r_cnt[7:0] <= rx_data;
          if (w_n == 16'd0) begin
            r_state   <= DONE;
            rx_ready  <= 1'b0;
            cpu_rst_o <= 1'b0;
            load_done <= 1'b1;
          end else if (w_n > DEPTH16) begin
            r_state  <= ERROR;
            rx_ready <= 1'b0;
            load_err <= 1'b1;
          end else r_state <= BYTES;
        end
        BYTES: if (w_acc) begin
          r_asm <= {r_asm[AW-9:0], rx_data};
          if (r_bidx == 3'd0 && |rx_data[7:1]) begin
            r_state  <= ERROR;
            rx_ready <= 1'b0;
            load_err <= 1'b1;
          end else if (r_bidx == 3'(NB - 1)) begin
            // r_asm already holds the low bits of the first NB-1 bytes
            r_bidx     <= 3'd0;
            r_state    <= WRITE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b1;
            imem_wdata <= {r_asm, rx_data};
          end else r_bidx <= r_bidx + 3'd1;
        end
        WRITE: if (16'(imem_addr) + 16'd1 == r_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_state  <= CSUM;
          rx_ready <= 1'b1;
`else
          r_state   <= DONE;
          cpu_rst_o <= 1'b0;
          load_done <= 1'b1;
`endif
        end else begin
          imem_addr <= imem_addr + ADDR_W'(1);
          rx_ready  <= 1'b1;
          r_state   <= BYTES;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (w_acc) begin
          rx_ready <= 1'b0;
          if (rx_data == r_csum) begin
            r_state   <= DONE;
            cpu_rst_o <= 1'b0;
            load_done <= 1'b1;
          end else begin
            r_state  <= ERROR;
            load_err <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default build, no checksum byte)
module tb_imem_loader;
  logic        clk = 1'b0, rst = 1'b1, load_start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, imem_we, cpu_rst_o, load_done, load_err;
  logic [8:0]  imem_addr;
  logic [32:0] imem_wdata;
  int tests = 0, failed = 0, nwr = 0;
  logic [8:0]  wa [64];
  logic [32:0] wd [64];
  logic [7:0]  f1 [12] = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_o(cpu_rst_o), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem_we && nwr < 64) begin
      wa[nwr] = imem_addr;
      wd[nwr] = imem_wdata;
      nwr = nwr + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start;
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit ok = 0;
    tick(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_f1(input bit jitter);
    for (int i = 0; i < 12; i++) send(f1[i], jitter ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic chk_f1(input int base);
    tick(2);
    chk("f1_count", 64'(nwr), 64'(base + 2));
    chk("f1_addr0", 64'(wa[base]), 64'd0);
    chk("f1_data0", 64'(wd[base]), 64'h1_2345_6789);
    chk("f1_addr1", 64'(wa[base+1]), 64'd1);
    chk("f1_data1", 64'(wd[base+1]), 64'h0_AABB_CCDD);
    chk("f1_done", 64'(load_done), 64'd1);
    chk("f1_cpu_rst", 64'(cpu_rst_o), 64'd0);
    chk("f1_rx_ready", 64'(rx_ready), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, {rx_ready, imem_we, cpu_rst_o, load_done, load_err}, 5'b0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
  endtask

  initial begin
    int base;
    tick(2);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(1);
    chk("idle_ready", 64'(rx_ready), 64'd0);
    // Test 1: two-instruction frame, plus latency check on the first write
    start();
    chk("hdr0_cpu_rst", 64'(cpu_rst_o), 64'd1);
    chk("hdr0_ready", 64'(rx_ready), 64'd1);
    for (int i = 0; i < 7; i++) send(f1[i], 0);
    @(negedge clk);
    chk("we_latency", 64'(imem_we), 64'd1);
    chk("write_ready_low", 64'(rx_ready), 64'd0);
    for (int i = 7; i < 12; i++) send(f1[i], 0);
    chk_f1(0);
    // bytes offered while not ready are ignored
    rx_data = 8'h55; rx_valid = 1'b1;
    tick(3);
    rx_valid = 1'b0;
    chk("done_hold", {load_done, cpu_rst_o, rx_ready}, 3'b100);
    // Test 2: empty program
    base = nwr;
    start();
    send(8'h00, 0);
    send(8'h00, 0);
    chk("n0_done", 64'(load_done), 64'd1);
    chk("n0_cpu_rst", 64'(cpu_rst_o), 64'd0);
    tick(2);
    chk("n0_no_write", 64'(nwr), 64'(base));
    // Test 3: N=513 exceeds depth
    start();
    send(8'h02, 0);
    send(8'h01, 0);
    chk("big_err", {load_err, cpu_rst_o, rx_ready, load_done}, 4'b1100);
    start();
    chk("restart_err_clr", {load_err, rx_ready, cpu_rst_o}, 3'b011);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("restart_done", 64'(load_done), 64'd1);
    // Test 4a: illegal first instruction byte
    base = nwr;
    start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    tick(2);
    chk("badbyte_err", {load_err, cpu_rst_o, load_done, rx_ready}, 4'b1100);
    chk("badbyte_no_write", 64'(nwr), 64'(base));
    // Test 4b: same frame as test 1 with random bubbles
    base = nwr;
    start();
    send_f1(1);
    chk_f1(base);
    // Test 5: reset mid-load, then a full reload
    start();
    for (int i = 0; i < 5; i++) send(f1[i], 0);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("midrst");
    rst = 1'b0;
    base = nwr;
    start();
    send_f1(0);
    chk_f1(base);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
